// File: rtl/branch_predict_unit.sv
// Two-bit-counter branch predictor with in-flight branch queue and BTB update path; optional stats via BPU_STATS_EN.
// Latency: prediction/mispredict combinational, BTB write registered one cycle after resolution.
// Backpressure: q_full stalls fetch; a push while full is taken only alongside a correct pop.
module branch_predict_unit #(
    parameter int QDEPTH = 4,
    parameter int IDX_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             fetch_br,
    input  logic [31:0]      fetch_pc,
    output logic [IDX_W-1:0] btb_rind,
    input  logic [1:0]       btb_rstate,
    input  logic [31:0]      btb_rtarget,
    output logic             pred_taken,
    output logic [31:0]      pred_pc,
    output logic             q_full,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             mispredict,
    output logic [31:0]      correct_pc,
    output logic             btb_wen,
    output logic [IDX_W-1:0] btb_wind,
    output logic [1:0]       btb_wstate,
    output logic [31:0]      btb_wtarget,
    output logic [31:0]      stat_br,
    output logic [31:0]      stat_mp
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [IDX_W-1:0] idx;
        logic [1:0]       st;
        logic             pt;
        logic [31:0]      ppc;
    } qent_t;

    qent_t          q_mem [QDEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    qent_t          head, new_ent;
    logic           pop, push;
    logic [1:0]     next_st;
    logic [31:0]    next_tgt;

    assign btb_rind   = fetch_pc[IDX_W+1:2];
    assign pred_taken = fetch_br & btb_rstate[1];
    assign pred_pc    = pred_taken ? btb_rtarget : fetch_pc + 32'd4;
    assign q_full     = (count == CW'(QDEPTH));

    assign head = q_mem[rd_ptr];
    assign pop  = res_valid & (count != '0);

    assign mispredict = pop & ((res_taken != head.pt) |
                               (res_taken & (res_target != head.ppc)));
    assign correct_pc = !mispredict ? 32'd0 :
                        res_taken   ? res_target : head.pc + 32'd4;

    // A full queue still accepts a push when the head leaves cleanly this cycle.
    assign push = fetch_br & ~mispredict & (~q_full | pop);

    always_comb begin
        new_ent     = '0;
        new_ent.pc  = fetch_pc;
        new_ent.idx = btb_rind;
        new_ent.st  = btb_rstate;
        new_ent.pt  = pred_taken;
        new_ent.ppc = pred_pc;
    end

    always_comb begin
        next_st = head.st;
        if (res_taken) begin
            if (head.st != 2'b11) next_st = head.st + 2'b01;
        end else begin
            if (head.st != 2'b00) next_st = head.st - 2'b01;
        end
    end

    assign next_tgt = res_taken    ? res_target :
                      head.st[1]   ? head.ppc   : head.pc + 32'd4;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= new_ent;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btb_wen     <= 1'b0;
            btb_wind    <= '0;
            btb_wstate  <= 2'b00;
            btb_wtarget <= '0;
        end else begin
            btb_wen <= pop;
            if (pop) begin
                btb_wind    <= head.idx;
                btb_wstate  <= next_st;
                btb_wtarget <= next_tgt;
            end
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_br <= '0;
            stat_mp <= '0;
        end else begin
            if (pop && stat_br != 32'hFFFF_FFFF)        stat_br <= stat_br + 32'd1;
            if (mispredict && stat_mp != 32'hFFFF_FFFF) stat_mp <= stat_mp + 32'd1;
        end
    end
`else
    assign stat_br = 32'd0;
    assign stat_mp = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized + directed bench for branch_predict_unit against a queue-based reference model.
module tb_branch_predict_unit;
    localparam int QD = 4;
    localparam int IW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          fetch_br = 1'b0;
    logic [31:0]   fetch_pc = '0;
    logic [IW-1:0] btb_rind;
    logic [1:0]    btb_rstate = '0;
    logic [31:0]   btb_rtarget = '0;
    logic          pred_taken;
    logic [31:0]   pred_pc;
    logic          q_full;
    logic          res_valid = 1'b0;
    logic          res_taken = 1'b0;
    logic [31:0]   res_target = '0;
    logic          mispredict;
    logic [31:0]   correct_pc;
    logic          btb_wen;
    logic [IW-1:0] btb_wind;
    logic [1:0]    btb_wstate;
    logic [31:0]   btb_wtarget;
    logic [31:0]   stat_br, stat_mp;

    branch_predict_unit #(.QDEPTH(QD), .IDX_W(IW)) dut (
        .CLK(CLK), .RST(RST), .fetch_br(fetch_br), .fetch_pc(fetch_pc),
        .btb_rind(btb_rind), .btb_rstate(btb_rstate), .btb_rtarget(btb_rtarget),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .q_full(q_full),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .mispredict(mispredict), .correct_pc(correct_pc),
        .btb_wen(btb_wen), .btb_wind(btb_wind), .btb_wstate(btb_wstate),
        .btb_wtarget(btb_wtarget), .stat_br(stat_br), .stat_mp(stat_mp)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        int          st;
        bit          pt;
        logic [31:0] ppc;
    } ent_t;

    ent_t        mq[$];
    bit          x_wen;
    logic [31:0] x_wind, x_wstate, x_wtarget;
    logic [31:0] x_br, x_mp;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        x_wen = 0; x_wind = 0; x_wstate = 0; x_wtarget = 0; x_br = 0; x_mp = 0;
    endtask

    // One clock: drive, check combinational outputs, clock, advance model, check registered outputs.
    task automatic cyc(input bit br, input logic [31:0] pc, input logic [1:0] st,
                       input logic [31:0] tgt, input bit rv, input bit rt, input logic [31:0] rtg);
        bit          e_pt, e_full, e_pop, e_mp, e_push;
        logic [31:0] e_ppc, e_cpc;
        ent_t        h;
        fetch_br = br; fetch_pc = pc; btb_rstate = st; btb_rtarget = tgt;
        res_valid = rv; res_taken = rt; res_target = rtg;
        #2;
        e_pt   = br && st >= 2;
        e_ppc  = e_pt ? tgt : pc + 4;
        e_full = (mq.size() == QD);
        e_pop  = rv && mq.size() > 0;
        e_mp   = 0;
        e_cpc  = 0;
        if (e_pop) begin
            h    = mq[0];
            e_mp = (rt != h.pt) || (rt && rtg != h.ppc);
            if (e_mp) e_cpc = rt ? rtg : h.pc + 4;
        end
        chk("btb_rind",   32'(btb_rind), (pc >> 2) % (1 << IW));
        chk("pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("pred_pc",    pred_pc, e_ppc);
        chk("q_full",     32'(q_full), 32'(e_full));
        chk("mispredict", 32'(mispredict), 32'(e_mp));
        chk("correct_pc", correct_pc, e_cpc);
        @(posedge CLK);
        e_push = br && !e_mp && (!e_full || e_pop);
        x_wen  = e_pop;
        if (e_pop) begin
            void'(mq.pop_front());
            x_wind    = (h.pc >> 2) % (1 << IW);
            x_wstate  = rt ? (h.st == 3 ? 3 : h.st + 1) : (h.st == 0 ? 0 : h.st - 1);
            x_wtarget = rt ? rtg : (h.st >= 2 ? h.ppc : h.pc + 4);
`ifdef BPU_STATS_EN
            if (x_br != 32'hFFFF_FFFF) x_br++;
            if (e_mp && x_mp != 32'hFFFF_FFFF) x_mp++;
`endif
        end
        if (e_mp) mq.delete();
        else if (e_push) mq.push_back('{pc, int'(st), e_pt, e_ppc});
        #1;
        chk("btb_wen", 32'(btb_wen), 32'(x_wen));
        if (x_wen) begin
            chk("btb_wind",    32'(btb_wind), x_wind);
            chk("btb_wstate",  32'(btb_wstate), x_wstate);
            chk("btb_wtarget", btb_wtarget, x_wtarget);
        end
        chk("stat_br", stat_br, x_br);
        chk("stat_mp", stat_mp, x_mp);
    endtask

    initial begin
        bit          rb, rv, rt;
        logic [31:0] pc, tgt, rtg;
        logic [1:0]  st;
        model_reset();
        #12;
        chk("rst_btb_wen",     32'(btb_wen), 32'd0);
        chk("rst_btb_wind",    32'(btb_wind), 32'd0);
        chk("rst_btb_wstate",  32'(btb_wstate), 32'd0);
        chk("rst_btb_wtarget", btb_wtarget, 32'd0);
        chk("rst_q_full",      32'(q_full), 32'd0);
        chk("rst_stat_br",     stat_br, 32'd0);
        chk("rst_stat_mp",     stat_mp, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // SNT fetch at 0x100 predicts fall-through; WT fetch with matching resolution updates to ST.
        cyc(1, 32'h100, 2'b00, 32'h999, 0, 0, 0);
        chk("snt_pred_pc_const", 32'h104, mq[0].ppc);
        cyc(1, 32'h300, 2'b10, 32'h200, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h200);
        chk("wt_wstate_st", 32'(btb_wstate), 32'd3);

        // WNT at 0x40 resolved taken to 0x80: redirect, flush, counter to WT.
        cyc(1, 32'h40, 2'b01, 32'h0, 0, 0, 0);
        cyc(1, 32'h44, 2'b00, 32'h0, 1, 1, 32'h80);
        cyc(0, 0, 0, 0, 1, 1, 32'h80);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Fill to QD, then push alongside a correct pop.
        for (int i = 0; i < QD; i++) cyc(1, 32'h1000 + 32'(i * 4), 2'b00, 0, 0, 0, 0);
        cyc(1, 32'h2000, 2'b00, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'hDEAD_0000);

        // Three resolutions, last one mispredicts.
        cyc(1, 32'h500, 2'b11, 32'h600, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h600);
        cyc(1, 32'h504, 2'b00, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 32'h508, 2'b01, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h700);

        for (int n = 0; n < 400; n++) begin
            rb  = ($urandom_range(0, 2) != 0);
            pc  = {20'h0, 10'($urandom), 2'b00};
            st  = 2'($urandom);
            tgt = {20'h0, 10'($urandom_range(0, 7)), 2'b00};
            rv  = $urandom_range(0, 1);
            rt  = $urandom_range(0, 1);
            rtg = {20'h0, 10'($urandom_range(0, 7)), 2'b00};
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rt  = mq[0].pt;
                rtg = mq[0].ppc;
            end
            cyc(rb, pc, st, tgt, rv, rt, rtg);
        end

        // Reset landing on a pending BTB update.
        cyc(1, 32'h900, 2'b00, 0, 1, 1, 32'hFFF0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        RST = 1'b1;
        #1;
        chk("rst_mid_btb_wen",    32'(btb_wen), 32'd0);
        chk("rst_mid_btb_wstate", 32'(btb_wstate), 32'd0);
        chk("rst_mid_stat_br",    stat_br, 32'd0);
        chk("rst_mid_q_full",     32'(q_full), 32'd0);
        model_reset();
        #3 RST = 1'b0;
        @(posedge CLK); #1;
        cyc(0, 0, 0, 0, 1, 1, 32'h40);
        cyc(1, 32'hA00, 2'b10, 32'hB00, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'hB00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
